// File: rtl/uart_core_if.sv
// Register-port bus between the polling echo master and uart_core.
interface uart_core_if;
    logic       adrs;
    logic       CSn;
    logic       OE;
    logic       WE;
    logic [7:0] data_in;
    logic [7:0] data_out;

    modport master (output adrs, CSn, OE, WE, data_in, input  data_out);
    modport slave  (input  adrs, CSn, OE, WE, data_in, output data_out);
endinterface

// File: rtl/uart_core.sv
// Byte-wide UART with status/data register port, fixed baud divider and optional parity.
module uart_core #(
    parameter int unsigned BAUD_DIV   = 434,
    parameter bit          PARITY_EN  = 1'b1,
    parameter bit          PARITY_ODD = 1'b0
) (
    input  logic       clk,
    input  logic       reset_ns,
    uart_core_if.slave bus,
    input  logic       rx,
    output logic       tx
);
    localparam int unsigned  CW       = $clog2(BAUD_DIV);
    localparam logic [CW-1:0] BIT_END  = CW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] HALF_END = CW'(BAUD_DIV / 2 - 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_e;

    // Bus decode; read side effects fire only on the first edge of a strobe
    logic rd_q;
    logic rd_c, rd_edge_c, data_rd_c, stat_rd_c, wr_c;
    logic [7:0] status_c;

    logic          tx_q, tx_d, tx_busy_q, tx_busy_d, tx_full_q, tx_full_d, tx_par_q, tx_par_d;
    logic          tx_load_c, tx_tick_c;
    state_e        tx_state_q, tx_state_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]    tx_bit_q, tx_bit_d;
    logic [7:0]    tx_shift_q, tx_shift_d, tx_hold_q, tx_hold_d;

    logic          rx_s1_q, rx_s2_q, rx_prev_q, rx_fall_c, rx_tick_c, rx_done_c;
    state_e        rx_state_q, rx_state_d;
    logic [CW-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]    rx_bit_q, rx_bit_d;
    logic [7:0]    rx_shift_q, rx_shift_d, rx_hold_q, rx_hold_d;
    logic          rx_par_q, rx_par_d, rxrdy_q, rxrdy_d;
    logic          perr_q, perr_d, ovf_q, ovf_d, ferr_q, ferr_d;

    assign rd_c      = !bus.CSn && bus.OE;
    assign rd_edge_c = rd_c && !rd_q;
    assign data_rd_c = rd_edge_c && !bus.adrs;
    assign stat_rd_c = rd_edge_c && bus.adrs;
    assign wr_c      = !bus.CSn && bus.WE && !bus.adrs;

    assign status_c     = {2'b00, perr_q, ovf_q, ferr_q, tx_busy_q, !tx_full_q, rxrdy_q};
    assign bus.data_out = bus.CSn ? 8'h00 : (bus.adrs ? status_c : rx_hold_q);
    assign tx           = tx_q;

    // TX next state; the line value is derived from the state being entered
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_par_d   = tx_par_q;
        tx_busy_d  = tx_busy_q;
        tx_full_d  = tx_full_q;
        tx_hold_d  = tx_hold_q;
        tx_load_c  = 1'b0;
        tx_tick_c  = (tx_cnt_q == BIT_END);
        if (tx_state_q != S_IDLE) tx_cnt_d = tx_tick_c ? '0 : tx_cnt_q + CW'(1);
        case (tx_state_q)
            S_IDLE:   if (tx_full_q) tx_load_c = 1'b1;
            S_START:  if (tx_tick_c) begin
                          tx_state_d = S_DATA;
                          tx_bit_d   = 3'd0;
                      end
            S_DATA:   if (tx_tick_c) begin
                          tx_shift_d = {1'b0, tx_shift_q[7:1]};
                          tx_bit_d   = tx_bit_q + 3'd1;
                          if (tx_bit_q == 3'd7) tx_state_d = PARITY_EN ? S_PARITY : S_STOP;
                      end
            S_PARITY: if (tx_tick_c) tx_state_d = S_STOP;
            S_STOP:   if (tx_tick_c) begin
                          if (tx_full_q) tx_load_c = 1'b1;
                          else begin
                              tx_state_d = S_IDLE;
                              tx_busy_d  = 1'b0;
                          end
                      end
            default:  tx_state_d = S_IDLE;
        endcase
        if (tx_load_c) begin
            tx_state_d = S_START;
            tx_cnt_d   = '0;
            tx_shift_d = tx_hold_q;
            tx_par_d   = (^tx_hold_q) ^ PARITY_ODD;
            tx_busy_d  = 1'b1;
            tx_full_d  = 1'b0;
        end else if (wr_c && !tx_full_q) begin
            tx_full_d = 1'b1;
            tx_hold_d = bus.data_in;
        end
        case (tx_state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = tx_shift_d[0];
            S_PARITY: tx_d = tx_par_d;
            default:  tx_d = 1'b1;
        endcase
    end

    assign rx_fall_c = rx_prev_q && !rx_s2_q;
    assign rx_tick_c = (rx_cnt_q == BIT_END);

    // RX next state plus status flag update (sets win over clears)
    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = (rx_state_q == S_IDLE || rx_tick_c) ? '0 : rx_cnt_q + CW'(1);
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_par_d   = rx_par_q;
        rx_done_c  = 1'b0;
        case (rx_state_q)
            S_IDLE:   if (rx_fall_c) rx_state_d = S_START;
            S_START:  if (rx_cnt_q == HALF_END) begin
                          rx_cnt_d   = '0;
                          rx_bit_d   = 3'd0;
                          rx_state_d = rx_s2_q ? S_IDLE : S_DATA;
                      end
            S_DATA:   if (rx_tick_c) begin
                          rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
                          rx_bit_d   = rx_bit_q + 3'd1;
                          if (rx_bit_q == 3'd7) rx_state_d = PARITY_EN ? S_PARITY : S_STOP;
                      end
            S_PARITY: if (rx_tick_c) begin
                          rx_par_d   = rx_s2_q;
                          rx_state_d = S_STOP;
                      end
            S_STOP:   if (rx_tick_c) begin
                          rx_done_c  = 1'b1;
                          rx_state_d = S_IDLE;
                      end
            default:  rx_state_d = S_IDLE;
        endcase

        rx_hold_d = rx_hold_q;
        rxrdy_d   = rxrdy_q && !data_rd_c;
        perr_d    = perr_q && !stat_rd_c;
        ovf_d     = ovf_q  && !stat_rd_c;
        ferr_d    = ferr_q && !stat_rd_c;
        if (rx_done_c) begin
            if (!rxrdy_q || data_rd_c) begin
                rx_hold_d = rx_shift_q;
                rxrdy_d   = 1'b1;
                if (PARITY_EN && (rx_par_q != ((^rx_shift_q) ^ PARITY_ODD))) perr_d = 1'b1;
                if (!rx_s2_q) ferr_d = 1'b1;
            end else begin
                ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_ns) begin
        if (!reset_ns) begin
            rd_q       <= 1'b0;
            tx_state_q <= S_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= 3'd0;
            tx_shift_q <= 8'h00;
            tx_hold_q  <= 8'h00;
            tx_par_q   <= 1'b0;
            tx_busy_q  <= 1'b0;
            tx_full_q  <= 1'b0;
            tx_q       <= 1'b1;
        end else begin
            rd_q       <= rd_c;
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_hold_q  <= tx_hold_d;
            tx_par_q   <= tx_par_d;
            tx_busy_q  <= tx_busy_d;
            tx_full_q  <= tx_full_d;
            tx_q       <= tx_d;
        end
    end

    always_ff @(posedge clk or negedge reset_ns) begin
        if (!reset_ns) begin
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_state_q <= S_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= 3'd0;
            rx_shift_q <= 8'h00;
            rx_hold_q  <= 8'h00;
            rx_par_q   <= 1'b0;
            rxrdy_q    <= 1'b0;
            perr_q     <= 1'b0;
            ovf_q      <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            rx_s1_q    <= rx;
            rx_s2_q    <= rx_s1_q;
            rx_prev_q  <= rx_s2_q;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_hold_q  <= rx_hold_d;
            rx_par_q   <= rx_par_d;
            rxrdy_q    <= rxrdy_d;
            perr_q     <= perr_d;
            ovf_q      <= ovf_d;
            ferr_q     <= ferr_d;
        end
    end
endmodule

// File: tb/tb_uart_core.sv
// Self-checking bench for uart_core: loopback, back-to-back TX, overflow, errors, collision, reset.
module tb_uart_core;
    localparam int unsigned B    = 8;
    localparam bit          PEN  = 1'b1;
    localparam bit          PODD = 1'b0;

    logic clk = 1'b0;
    logic reset_ns = 1'b0;
    logic rx_drv = 1'b1;
    logic loop_en = 1'b0;
    logic rx, tx;

    uart_core_if bus ();

    uart_core #(.BAUD_DIV(B), .PARITY_EN(PEN), .PARITY_ODD(PODD)) dut (
        .clk      (clk),
        .reset_ns (reset_ns),
        .bus      (bus.slave),
        .rx       (rx),
        .tx       (tx)
    );

    assign rx = loop_en ? tx : rx_drv;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model of the receive-side register state
    bit         m_rxrdy = 1'b0, m_ovf = 1'b0, m_perr = 1'b0, m_ferr = 1'b0;
    logic [7:0] m_hold = 8'h00;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic par_of(input logic [7:0] d);
        return (^d) ^ PODD;
    endfunction

    function automatic logic [10:0] frame_of(input logic [7:0] d);
        return {1'b1, par_of(d), d, 1'b0};
    endfunction

    function automatic void m_frame(input logic [7:0] d, input bit par_ok, input bit stop_ok);
        if (!m_rxrdy) begin
            m_hold  = d;
            m_rxrdy = 1'b1;
            if (!par_ok)  m_perr = 1'b1;
            if (!stop_ok) m_ferr = 1'b1;
        end else begin
            m_ovf = 1'b1;
        end
    endfunction

    function automatic void m_reset();
        m_rxrdy = 1'b0; m_ovf = 1'b0; m_perr = 1'b0; m_ferr = 1'b0; m_hold = 8'h00;
    endfunction

    task automatic bus_rd(input logic a, output logic [7:0] d);
        @(negedge clk);
        bus.CSn = 1'b0; bus.adrs = a; bus.OE = 1'b1;
        #1 d = bus.data_out;
        @(negedge clk);
        bus.CSn = 1'b1; bus.OE = 1'b0;
    endtask

    task automatic bus_wr(input logic [7:0] d);
        @(negedge clk);
        bus.CSn = 1'b0; bus.adrs = 1'b0; bus.WE = 1'b1; bus.data_in = d;
        @(negedge clk);
        bus.CSn = 1'b1; bus.WE = 1'b0;
    endtask

    task automatic chk_status(input string tag, input bit busy);
        logic [7:0] v;
        bus_rd(1'b1, v);
        check(tag, v, {2'b00, m_perr, m_ovf, m_ferr, busy, 1'b1, m_rxrdy});
        m_perr = 1'b0; m_ovf = 1'b0; m_ferr = 1'b0;
    endtask

    task automatic chk_data(input string tag);
        logic [7:0] v;
        bus_rd(1'b0, v);
        check(tag, v, m_hold);
        m_rxrdy = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] d, input bit bad_par, input bit bad_stop);
        logic [10:0] f;
        f = frame_of(d);
        f[9]  = f[9] ^ bad_par;
        f[10] = !bad_stop;
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            rx_drv = f[i];
            repeat (B - 1) @(negedge clk);
        end
        @(negedge clk);
        rx_drv = 1'b1;
        repeat (2 * B) @(negedge clk);
    endtask

    task automatic tx_capture(input int nbits, output logic [31:0] bits, output bit seen);
        bits = '0;
        seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clk);
            if (tx === 1'b0) seen = 1'b1;
        end
        if (seen) begin
            repeat (B / 2) @(negedge clk);
            for (int i = 0; i < nbits; i++) begin
                bits[i] = tx;
                repeat (B) @(negedge clk);
            end
        end
    endtask

    task automatic wait_rxrdy(input string tag, output int lat);
        logic [7:0] v;
        time        t0;
        bit         got;
        t0  = $time;
        got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            bus_rd(1'b1, v);
            if (v[0]) got = 1'b1;
        end
        lat = int'(($time - t0) / 10);
        check({tag, "_rxrdy_seen"}, 32'(got), 32'd1);
        if (got) check({tag, "_err_bits"}, 32'(v[5:3]), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, stopping");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  v, v2, d;
        logic [31:0] bits;
        bit          seen, found;
        int          lat, e;

        bus.CSn = 1'b1; bus.OE = 1'b0; bus.WE = 1'b0; bus.adrs = 1'b0; bus.data_in = 8'h00;
        repeat (3) @(negedge clk);
        reset_ns = 1'b1;

        // Reset state
        #1 check("rst_tx", 32'(tx), 32'd1);
        check("rst_dout_cs_hi", 32'(bus.data_out), 32'd0);
        chk_status("rst_status", 1'b0);
        chk_data("rst_data");

        // Loopback of A5 with latency window
        loop_en = 1'b1;
        bus_wr(8'hA5);
        wait_rxrdy("lb", lat);
        check("lb_latency_ok", 32'(lat >= 84 && lat <= 100), 32'd1);
        m_frame(8'hA5, 1'b1, 1'b1);
        repeat (2 * B) @(negedge clk);
        chk_status("lb_status", 1'b0);
        chk_data("lb_data");
        chk_status("lb_status_after", 1'b0);

        // Random loopback bytes
        for (int i = 0; i < 6; i++) begin
            d = 8'($urandom);
            bus_wr(d);
            wait_rxrdy($sformatf("rlb%0d", i), lat);
            m_frame(d, 1'b1, 1'b1);
            repeat (2 * B) @(negedge clk);
            chk_status($sformatf("rlb%0d_status", i), 1'b0);
            chk_data($sformatf("rlb%0d_data", i));
        end
        loop_en = 1'b0;

        // Back-to-back frames, third write dropped
        fork
            tx_capture(22, bits, seen);
            begin
                bus_wr(8'h55);
                bus_rd(1'b1, v);
                check("b2b_status_loaded", 32'(v), 32'h06);
                bus_wr(8'h0F);
                bus_rd(1'b1, v2);
                check("b2b_status_full", 32'(v2), 32'h04);
                bus_wr(8'hFF);
            end
        join
        check("b2b_seen", 32'(seen), 32'd1);
        check("b2b_frames", bits, {10'b0, frame_of(8'h0F), frame_of(8'h55)});
        tx_capture(1, bits, seen);
        check("b2b_third_dropped", 32'(seen), 32'd0);
        chk_status("b2b_idle_status", 1'b0);

        // Overflow
        send_frame(8'h11, 1'b0, 1'b0);
        m_frame(8'h11, 1'b1, 1'b1);
        send_frame(8'h22, 1'b0, 1'b0);
        m_frame(8'h22, 1'b1, 1'b1);
        chk_status("ovf_status1", 1'b0);
        chk_status("ovf_status2", 1'b0);
        chk_data("ovf_data");

        // Parity error, framing error, glitch
        send_frame(8'h6B, 1'b1, 1'b0);
        m_frame(8'h6B, 1'b0, 1'b1);
        chk_status("perr_status", 1'b0);
        chk_data("perr_data");
        send_frame(8'h94, 1'b0, 1'b1);
        m_frame(8'h94, 1'b1, 1'b0);
        chk_status("ferr_status", 1'b0);
        chk_data("ferr_data");
        @(negedge clk); rx_drv = 1'b0;
        repeat (2) @(negedge clk); rx_drv = 1'b1;
        repeat (12 * B) @(negedge clk);
        chk_status("glitch_status", 1'b0);

        // Random frames with random errors and skipped reads
        for (int i = 0; i < 8; i++) begin
            d = 8'($urandom);
            e = int'($urandom_range(0, 2));
            send_frame(d, e == 1, e == 2);
            m_frame(d, e != 1, e != 2);
            chk_status($sformatf("rnd%0d_status", i), 1'b0);
            if ($urandom_range(0, 1) == 1) chk_data($sformatf("rnd%0d_data", i));
        end
        chk_data("rnd_drain_data");
        chk_status("rnd_drain_status", 1'b0);

        // Data read landing on the stop-sample edge
        found = 1'b0;
        for (int k = 80; k <= 92 && !found; k++) begin
            bus_rd(1'b0, v);
            bus_rd(1'b1, v);
            send_frame(8'h3C, 1'b0, 1'b0);
            v2 = 8'h00;
            fork
                send_frame(8'hC5, 1'b0, 1'b0);
                begin
                    @(negedge clk);
                    repeat (k) @(negedge clk);
                    bus.CSn = 1'b0; bus.adrs = 1'b0; bus.OE = 1'b1;
                    @(negedge clk);
                    #1 v2 = bus.data_out;
                    @(negedge clk);
                    bus.CSn = 1'b1; bus.OE = 1'b0;
                end
            join
            if (v2 == 8'hC5) found = 1'b1;
        end
        check("coll_found", 32'(found), 32'd1);
        m_reset();
        m_frame(8'hC5, 1'b1, 1'b1);
        chk_status("coll_status", 1'b0);
        chk_data("coll_data");

        // Reset in the middle of a TX frame
        bus_wr(8'hC3);
        repeat (30) @(negedge clk);
        check("midframe_tx_low", 32'(tx), 32'd0);
        #2 reset_ns = 1'b0;
        #1 check("rst_mid_tx", 32'(tx), 32'd1);
        @(negedge clk);
        reset_ns = 1'b1;
        m_reset();
        chk_status("rst_mid_status", 1'b0);
        chk_data("rst_mid_data");
        tx_capture(1, bits, seen);
        check("rst_mid_no_resume", 32'(seen), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/uart_core.md
# uart_core

Byte-wide UART with a status/data register slave port. It is the peripheral directly downstream of the polling echo master. The master reads received bytes and status through `data_out`, and writes bytes to transmit through `data_in`, using `adrs`/`CSn`/`OE`/`WE` strobes. The core serializes and deserializes 8-bit frames on `tx`/`rx` at a fixed divided baud rate, with optional parity.

## Interface
- `BAUD_DIV`, 434, clocks per bit (50 MHz / 115200); must be ≥ 4
- `PARITY_EN`, 1, 1: parity bit present after data; 0: no parity bit
- `PARITY_ODD`, 0, 0: even parity; 1: odd parity
- `clk`  in  1  50 MHz system clock
- `reset_ns`  in  1  reset, asynchronous, active-low
- `adrs`  in  1  register select, 1: status, 0: data
- `CSn`  in  1  chip select, active-low
- `OE`  in  1  read strobe, active-high
- `WE`  in  1  write strobe, active-high
- `data_in`  in  8  byte to transmit
- `data_out`  out  8  register read data
- `rx`  in  1  serial input, idle high, asynchronous
- `tx`  out  1  serial output, idle high

## Operation
- **Status register** `{2'b00, parity_err, overflow, framing_err, tx_busy, TXrdy, RXrdy}`.
- **`data_out`** is combinational:
  - `!CSn && adrs` → status
  - `!CSn && !adrs` → rx holding register
  - `CSn` high → 8'h00
- **Read side effects.** A read is `!CSn && OE`. Side effects act once, on the first clock edge of a strobe (the strobe is edge-detected against its registered previous value).
  - Data read clears `RXrdy`.
  - Status read clears `parity_err`, `overflow` and `framing_err`.
- **Write.** A write is `!CSn && WE && !adrs`.
  - If `TXrdy`=1: `data_in` is loaded into the tx holding register and `TXrdy`←0.
  - If `TXrdy`=0: the write is dropped.
  - Writes with `adrs`=1 are ignored.
- **TX FSM** states IDLE→START→DATA(8 bits, LSB first)→PARITY (only if `PARITY_EN`)→STOP→IDLE.
  - Each bit lasts `BAUD_DIV` clocks.
  - In IDLE with the holding register full: the shifter loads, `TXrdy`←1, `tx_busy`←1, and the FSM goes to START.
  - At the end of STOP: with the holding register full, the FSM goes directly to START (back-to-back frames, no idle gap); otherwise it goes to IDLE and `tx_busy`←0.
- **RX input path.** `rx` passes through a 2-flop synchronizer whose flops reset to 1.
- **RX FSM** states IDLE→START→DATA→PARITY (only if `PARITY_EN`)→STOP→IDLE.
  - IDLE: a synchronized falling edge starts a half-bit count.
  - START: sample at mid-bit (`BAUD_DIV/2`). A high sample is a false start and returns to IDLE. Otherwise every later bit is sampled `BAUD_DIV` clocks apart.
  - STOP, at the sample edge:
    - If `RXrdy`=0 or a data read occurs on the same edge: load the byte and set `RXrdy`←1. Set `parity_err` on parity mismatch and `framing_err` if the stop sample is 0.
    - Else: set `overflow`←1. The holding register and `RXrdy` are unchanged, and parity/framing results are discarded.
  - The FSM returns to IDLE on the same edge and can detect a new start on the next cycle.
- **Simultaneous events.**
  - Error set and status-read clear on the same edge: set wins.
  - Data read and RX load on the same edge: new byte loaded, `RXrdy`=1, no overflow.
- **Reset** (async, mid-frame included) forces:
  - both FSMs to IDLE, all counters to 0
  - `tx`=1, `data_out` per mux (holding register 0)
  - status = 8'h02 (`TXrdy`=1, all other bits 0)
  - synchronizer flops = 1

## Timing
- Write accepted at edge E: `TXrdy`=0 after E. The shifter loads at E+1, `TXrdy` returns to 1, and `tx` goes low after E+1.
- Frame length on `tx` = (10 + `PARITY_EN`) × `BAUD_DIV` clocks.
- RX: `RXrdy` rises (2 sync + `BAUD_DIV/2` + (9+`PARITY_EN`) × `BAUD_DIV`) ±1 clocks after the falling start edge on `rx`.
- Bus reads are zero-wait: `data_out` is valid in the same cycle `CSn`/`adrs` are presented. The master samples it at the edge where `OE` is high.
- The bit counter runs 0..`BAUD_DIV`-1 and wraps. Its width is $clog2(`BAUD_DIV`).

## Test plan
- **Reset:** `reset_ns`=0 mid-TX-frame → `tx`=1 immediately; status read returns 8'h02 after release.
- **Loopback** (`tx`→`rx`, `BAUD_DIV`=8, even parity): write 8'hA5 → `RXrdy`=1 after 11×8+~6 clocks; data read returns 8'hA5 and `RXrdy`→0; status bits 5:3 = 0.
- **Back-to-back TX:** write 8'h55, then 8'h0F as soon as `TXrdy`=1 → two contiguous frames with no idle gap; a third write while `TXrdy`=0 is dropped.
- **Overflow:** drive two frames 8'h11, 8'h22 without reading → `data_out` (data) = 8'h11 and status = 8'h13 after the first read of status (bit4 set); a second status read returns bit4=0.
- **Errors:** frame with a wrong parity bit → `parity_err`=1; frame with stop=0 → `framing_err`=1; a 2-clock low glitch on `rx` → no reception.
- **Collision:** data read on the same edge as an RX stop sample → new byte held, `RXrdy`=1, `overflow`=0.
